// File: rtl/lut_neuron_pkg.sv
// Shared definitions for the LUT neuron pipeline.
//   state_e      : controller state (table clear, then normal operation)
//   lut_addr_w() : table address width from fan-in and input width
//   lut_depth()  : number of table entries for a given address width
package lut_neuron_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_FANIN    = 4;
  localparam int DEF_IN_BITS  = 2;
  localparam int DEF_OUT_BITS = 2;

  function automatic int lut_addr_w(input int fanin, input int in_bits);
    return fanin * in_bits;
  endfunction

  function automatic int lut_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// Truth-table storage: one write port, one registered read port,
// distributed-RAM style (no reset on the array).
//   clk, rst      : clock, sync active-high reset (read register only)
//   we/waddr/wdata: write port
//   re/raddr      : read enable/address; rdata updates one cycle later
//   rdata         : registered read data, holds while re=0
module lut_neuron_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register only loads on re, so a pending result is untouched by
  // later writes to the same entry.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/lut_neuron_pipe.sv
// LUT neuron: FANIN quantised inputs index a programmable truth table
// whose entry is the neuron output. After reset the table is cleared one
// entry per cycle, then lookups and config writes are served.
//   clk, rst                 : clock, sync active-high reset
//   s_valid/s_ready/s_data   : lookup request (input 0 in LSBs)
//   m_valid/m_ready/m_data   : lookup result, latency 1
//   cfg_we/cfg_addr/cfg_data : table write (ignored during clear)
//   init_done                : table clear finished
module lut_neuron_pipe
  import lut_neuron_pkg::*;
#(
  parameter  int FANIN    = DEF_FANIN,
  parameter  int IN_BITS  = DEF_IN_BITS,
  parameter  int OUT_BITS = DEF_OUT_BITS,
  localparam int ADDR_W   = lut_addr_w(FANIN, IN_BITS),
  localparam int DEPTH    = lut_depth(ADDR_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [ADDR_W-1:0]   s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_BITS-1:0] m_data,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                init_done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                init_done_q, init_done_d;
  logic                m_valid_q, m_valid_d;
  logic                accept;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [OUT_BITS-1:0] ram_wdata;

  // Config write wins over a lookup in the same cycle; the output slot
  // frees up when empty or being drained.
  assign s_ready = (state_q == ST_RUN) & ~cfg_we & (~m_valid_q | m_ready);
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    if (accept)       m_valid_d = 1'b1;
    else if (m_ready) m_valid_d = 1'b0;
  end

  // Clear writes own the port during INIT; cfg_we is ignored there.
  always_comb begin
    ram_we    = cfg_we;
    ram_waddr = cfg_addr;
    ram_wdata = cfg_data;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt_q;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      m_valid_q   <= m_valid_d;
    end
  end

  lut_neuron_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (OUT_BITS)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .raddr (s_data),
    .rdata (m_data)
  );

  assign m_valid   = m_valid_q;
  assign init_done = init_done_q;

endmodule
